// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// One result bit per cycle; signed ops run on magnitudes and are sign-fixed in FIXUP.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       rem_q;
    logic [WIDTH-1:0]       opnd_q;
    logic                   is_div_q, res_neg_q, rem_neg_q, div0_q;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   done_q;

    logic                   a_neg, b_neg, div_op, div_zero, accept, last_iter;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum, div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_sub;
    logic [2*WIDTH-1:0]     prod_fix, result;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    // Operand conditioning at issue; -MIN wraps to MIN, which is its correct unsigned magnitude.
    always_comb begin
        a_neg     = ~funct[0] & a[WIDTH-1];
        b_neg     = ~funct[0] & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div_op    = funct[1];
        div_zero  = div_op && (b == '0);
        accept    = (state_q == StIdle) && start && !flush;
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    // Shift-add multiply keeps the multiplier in acc low half; restoring divide shifts the
    // dividend out of acc low half while quotient bits shift in behind it.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    end

    always_comb begin
        prod_fix = res_neg_q ? -acc_q : acc_q;
        quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -rem_q : rem_q;
        if (div0_q) begin
            result = acc_q;
        end else if (is_div_q) begin
            result = {rem_fix, quo_fix};
        end else begin
            result = prod_fix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = div_zero ? StFixup : StCalc;
                StCalc:  if (last_iter) state_d = StFixup;
                StFixup: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cnt_q     <= '0;
                rem_q     <= '0;
                is_div_q  <= div_op;
                res_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                div0_q    <= div_zero;
                if (div_zero) begin
                    acc_q <= {a, {WIDTH{1'b1}}};
                end else if (div_op) begin
                    acc_q  <= {{WIDTH{1'b0}}, a_mag};
                    opnd_q <= b_mag;
                end else begin
                    acc_q  <= {{WIDTH{1'b0}}, b_mag};
                    opnd_q <= a_mag;
                end
            end else if (state_q == StCalc && !flush) begin
                cnt_q <= cnt_q + CntW'(1);
                if (is_div_q) begin
                    rem_q             <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                    acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                end
            end else if (state_q == StFixup && !flush) begin
                hi_q   <= result[2*WIDTH-1:WIDTH];
                lo_q   <= result[WIDTH-1:0];
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: results queued at issue, compared on each done pulse.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n, start, flush;
    logic [1:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           tests = 0;
    int           fails = 0;
    logic [63:0]  sb[$];
    logic [63:0]  last_exp = 64'd0;
    logic [63:0]  mon_exp;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0]        ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (f[1] && y == 32'd0) return {x, 32'hFFFFFFFF};
        case (f)
            2'd0: return sx * sy;
            2'd1: return ux * uy;
            2'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return {x % y, x / y};
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check_eq("hi", 64'(hi), 64'(mon_exp[63:32]));
                check_eq("lo", 64'(lo), 64'(mon_exp[31:0]));
            end
        end
    end

    // Issues in the current cycle (cycle 0) and returns in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input int exp_lat);
        int lat;
        int gaps;
        sb.push_back(exp);
        last_exp = exp;
        funct = f;
        a     = x;
        b     = y;
        start = 1'b1;
        lat   = 0;
        gaps  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                funct = 2'($urandom);
            end
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) gaps++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy"}, 64'(gaps), 64'd0);
        if (lat != 0) check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  rf;
        logic [31:0] rx, ry;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct   = 2'd0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 34);
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34);
        run_op("divu", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_op("div0", 2'd2, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 2);
        run_op("divu_b2b", 2'd3, 32'd9, 32'd2, {32'd1, 32'd4}, 34);

        for (int i = 0; i < 6; i++) begin
            rf = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            if (i == 2) ry = ry >> 28;
            if (i == 5) ry = 32'd0;
            run_op("rand", rf, rx, ry, model(rf, rx, ry), (rf[1] && ry == 32'd0) ? 2 : 34);
        end

        // Flush mid-CALC: no done, result registers keep the previous value.
        funct = 2'd1;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("flush_hilo", {hi, lo}, last_exp);

        // Flush in FIXUP (divide by zero reaches it in cycle 1) suppresses the write.
        funct = 2'd2;
        a     = 32'hCAFEF00D;
        b     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        check_eq("fix_busy_pre", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("fix_flush_busy", 64'(busy), 64'd0);
        check_eq("fix_flush_hilo", {hi, lo}, last_exp);

        // start and flush together: nothing is issued.
        funct = 2'd1;
        a     = 32'd7;
        b     = 32'd7;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check_eq("startflush_busy", 64'(busy), 64'd0);

        // Reset mid-CALC clears everything at once and no done follows.
        funct = 2'd0;
        a     = 32'd11;
        b     = 32'd13;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_done", 64'(done), 64'd0);
        check_eq("mid_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_hilo", {hi, lo}, 64'd0);

        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage consumer of the decoder's muldiv control fields: `muldiv_funct`, with `write_hi`/`write_lo` and `hilo_src` = `HILO_SRC_MULDIV`.
- Performs iterative MULT, MULTU, DIV and DIVU on rs/rt operands.
- Returns 64-bit results as hi/lo to the HI/LO register write path.
- Exposes busy/done so hazard logic can stall MFHI/MFLO and back-to-back muldiv ops until the result lands.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only in IDLE
- funct  input  2  `selector::muldiv_funct` value: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight op (exception or branch squash)
- busy  output  1  high while an op is in flight (state != IDLE)
- done  output  1  one-cycle pulse; hi/lo are valid this cycle
- hi  output  WIDTH  product high word, or remainder
- lo  output  WIDTH  product low word, or quotient

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; hi = 0, lo = 0; done = 0; busy = 0; internal counter and accumulators cleared.
  - Reset mid-op discards the op; no done pulse follows.
- States:
  - IDLE → CALC on start && !flush; operand latch on that edge.
  - IDLE → FIXUP directly when the op is a divide and b == 0.
  - CALC → FIXUP after WIDTH iterations, counter 0..WIDTH-1.
  - FIXUP → IDLE, writing hi/lo and asserting done.
- Operand latch, signed ops (MULT, DIV):
  - Take magnitudes of a and b (|0x80000000| = 0x80000000 as unsigned).
  - Record result sign = a[MSB]^b[MSB]; record remainder sign = a[MSB].
- Operand latch, unsigned ops: operands are used raw and both signs are 0.
- Multiply: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- Divide: radix-2 restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- FIXUP:
  - Two's-complement negate the product when the result sign is 1.
  - For divides: negate the quotient when the result sign is 1; negate the remainder when the remainder sign is 1.
  - Register the result into hi/lo.
- Divide by zero (DIV or DIVU, b == 0): hi = a unmodified, lo = all ones; done 2 cycles after start.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude scheme; no special case.
- Timing, with start high in cycle 0:
  - busy = 1 in cycles 1..WIDTH+1.
  - done = 1 and hi/lo updated in cycle WIDTH+2 (34 for WIDTH = 32); busy = 0 that cycle.
  - A new start is accepted in the done cycle.
- hi/lo hold their value between completions and change only on the FIXUP → IDLE edge.
- start while busy is ignored; the decoder side must stall on busy.
- flush:
  - Any state → IDLE on the next edge; hi/lo unchanged; no done.
  - flush in the FIXUP cycle also suppresses the write.
  - start && flush in the same IDLE cycle: flush wins, no op is started.
- Operands a, b and funct are ignored after the start cycle; they may change freely.
- done is registered, never combinational from inputs.

Test Plan:
- Reset with reset_n low mid-CALC → busy = 0, done = 0, hi = lo = 0 immediately; no later done.
- MULT a = 0xFFFFFFFD (-3), b = 5 → done at cycle 34, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, busy high in cycles 1..33.
- MULTU a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- Divides, one op each:
  - DIVU 100/7 → lo = 14, hi = 2.
  - DIV 0xFFFFFFF9 (-7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV 0x12345678 / 0 → done at cycle 2, hi = 0x12345678, lo = 0xFFFFFFFF.
- Flush and back-to-back:
  - Start MULTU 3*4, flush in cycle 10 → busy drops in cycle 11; no done; hi/lo retain the prior result.
  - Issue DIVU 9/2 in the done cycle of a prior op → accepted; lo = 4, hi = 1 at +34.
